// File: rtl/jt900h_ram8_bridge.sv
// Bridges the 16-bit CPU RAM port onto an 8-bit external memory, one byte phase at a time.
// Optional one-word read cache: define JT900H_RAM8_RDCACHE_EN.
module jt900h_ram8_bridge #(
   parameter int WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic [23:0] ram_addr,
   input  logic [15:0] ram_din,
   input  logic [1:0]  ram_we,
   input  logic        ram_rd,
   output logic [15:0] ram_dout,
   output logic        ram_ok,
   output logic [23:0] ext_addr,
   output logic        ext_cs,
   output logic        ext_we,
   output logic [7:0]  ext_dout,
   input  logic [7:0]  ext_din
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   localparam logic [2:0] WLAST = 3'(WAIT);

   state_t      state_q, state_d;
   logic [2:0]  wcnt_q, wcnt_d;
   logic [22:0] word_q, word_d;
   logic [15:0] din_q, din_d;
   logic [1:0]  mask_q, mask_d;
   logic        wr_q, wr_d;
   logic [15:0] dout_q, dout_d;
   logic        ok_q, ok_d;
   logic        cs_q, cs_d;
   logic        ewe_q, ewe_d;
   logic [23:0] eaddr_q, eaddr_d;
   logic [7:0]  edout_q, edout_d;
   logic        last;
   logic        in_phase_d;
   logic        rd_hit;
   logic        unused_addr0;

   // Word access only: the byte select bit of the CPU address carries no information.
   assign unused_addr0 = ram_addr[0];

`ifdef JT900H_RAM8_RDCACHE_EN
   logic        valid_q, valid_d;
   logic [22:0] tag_q, tag_d;

   assign rd_hit = valid_q && (tag_q == ram_addr[23:1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end
`else
   assign rd_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      word_d  = word_q;
      din_d   = din_q;
      mask_d  = mask_q;
      wr_d    = wr_q;
      dout_d  = dout_q;
      ok_d    = ok_q;
      cs_d    = cs_q;
      ewe_d   = ewe_q;
      eaddr_d = eaddr_q;
      edout_d = edout_q;
`ifdef JT900H_RAM8_RDCACHE_EN
      valid_d = valid_q;
      tag_d   = tag_q;
`endif
      last       = (wcnt_q == WLAST);
      in_phase_d = 1'b0;
      if (cen) begin
         case (state_q)
            IDLE: begin
               if (ram_we != 2'b00) begin
                  word_d  = ram_addr[23:1];
                  din_d   = ram_din;
                  mask_d  = ram_we;
                  wr_d    = 1'b1;
                  state_d = ram_we[0] ? LO : HI;
`ifdef JT900H_RAM8_RDCACHE_EN
                  if (tag_q == ram_addr[23:1]) valid_d = 1'b0;
`endif
               end else if (ram_rd) begin
                  word_d  = ram_addr[23:1];
                  din_d   = ram_din;
                  mask_d  = 2'b00;
                  wr_d    = 1'b0;
                  state_d = rd_hit ? DONE : LO;
               end
            end
            LO: begin
               if (last) begin
                  if (!wr_q) dout_d[7:0] = ext_din;
                  state_d = (!wr_q || mask_q[1]) ? HI : DONE;
               end
            end
            HI: begin
               if (last) begin
                  if (!wr_q) begin
                     dout_d[15:8] = ext_din;
`ifdef JT900H_RAM8_RDCACHE_EN
                     valid_d = 1'b1;
                     tag_d   = word_q;
`endif
                  end
                  state_d = DONE;
               end
            end
            default: state_d = IDLE;
         endcase

         // Outputs are computed from the next state so they leave the flops glitch-free.
         in_phase_d = (state_d == LO) || (state_d == HI);
         if (in_phase_d && (state_d != state_q)) wcnt_d = 3'd0;
         else if (in_phase_d && !last)           wcnt_d = wcnt_q + 3'd1;
         cs_d  = in_phase_d;
         ewe_d = in_phase_d && wr_d;
         if (in_phase_d) eaddr_d = {word_d, state_d == HI};
         if (ewe_d) edout_d = (state_d == HI) ? din_d[15:8] : din_d[7:0];
         ok_d = (state_d == DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= 3'd0;
         word_q  <= '0;
         din_q   <= '0;
         mask_q  <= 2'b00;
         wr_q    <= 1'b0;
         dout_q  <= '0;
         ok_q    <= 1'b0;
         cs_q    <= 1'b0;
         ewe_q   <= 1'b0;
         eaddr_q <= '0;
         edout_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         word_q  <= word_d;
         din_q   <= din_d;
         mask_q  <= mask_d;
         wr_q    <= wr_d;
         dout_q  <= dout_d;
         ok_q    <= ok_d;
         cs_q    <= cs_d;
         ewe_q   <= ewe_d;
         eaddr_q <= eaddr_d;
         edout_q <= edout_d;
      end
   end

   assign ram_dout = dout_q;
   assign ram_ok   = ok_q;
   assign ext_addr = eaddr_q;
   assign ext_cs   = cs_q;
   assign ext_we   = ewe_q;
   assign ext_dout = edout_q;

endmodule

// File: tb/tb_jt900h_ram8_bridge.sv
// Bench for jt900h_ram8_bridge: random transactions against a byte-array memory model.
// Define JT900H_RAM8_RDCACHE_EN to also expect read-cache behaviour.
module tb_jt900h_ram8_bridge;

   localparam int W = 1;
`ifdef JT900H_RAM8_RDCACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, cen;
   logic [23:0] ram_addr;
   logic [15:0] ram_din;
   logic [1:0]  ram_we;
   logic        ram_rd;
   logic [15:0] ram_dout;
   logic        ram_ok;
   logic [23:0] ext_addr;
   logic        ext_cs, ext_we;
   logic [7:0]  ext_dout, ext_din;

   int errors = 0;
   int checks = 0;

   // external memory device (owned by the monitor) and the reference image
   logic [7:0]  dev_mem[1024];
   logic [7:0]  ref_mem[1024];
   logic [23:0] cs_log[4096];
   int          cs_total = 0;

   // reference model state
   logic [15:0] exp_dout;
   bit          c_valid;
   logic [22:0] c_tag;

   jt900h_ram8_bridge #(.WAIT(W)) dut (
      .clk(clk), .rst(rst), .cen(cen),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_rd(ram_rd),
      .ram_dout(ram_dout), .ram_ok(ram_ok),
      .ext_addr(ext_addr), .ext_cs(ext_cs), .ext_we(ext_we),
      .ext_dout(ext_dout), .ext_din(ext_din)
   );

   always #5 clk = ~clk;

   assign ext_din = dev_mem[ext_addr[9:0]];

   // monitor: external device behaviour plus strobe sanity
   initial begin
      for (int i = 0; i < 1024; i++) dev_mem[i] = 8'(i * 37 + 11);
      forever begin
         @(negedge clk);
         if (!rst) begin
            checks++;
            if (ext_we && !ext_cs) begin
               errors++;
               $display("FAIL strobe: ext_we=%0b with ext_cs=%0b", ext_we, ext_cs);
            end
            if (cen && ext_cs) begin
               cs_log[cs_total % 4096] = ext_addr;
               cs_total++;
               if (ext_we) dev_mem[ext_addr[9:0]] = ext_dout;
            end
         end
      end
   end

   task automatic do_txn(input logic [23:0] a, input logic [15:0] d, input logic [1:0] we,
                         input logic rd, input bit cen_tog, input string name);
      logic [22:0] w;
      bit          is_wr, hit, got, cen_s;
      int          nb, exp_lat, exp_cs, lat, cnt, start;
      logic [23:0] exp_first;
      w         = a[23:1];
      is_wr     = (we != 2'b00);
      hit       = CACHE && !is_wr && c_valid && (c_tag == w);
      nb        = is_wr ? (int'(we[0]) + int'(we[1])) : 2;
      exp_cs    = hit ? 0 : nb * (W + 1);
      exp_lat   = exp_cs + 1;
      exp_first = (is_wr && !we[0]) ? {w, 1'b1} : {w, 1'b0};
      start     = cs_total;

      ram_addr = a; ram_din = d; ram_we = we; ram_rd = rd; cen = 1'b1;
      @(posedge clk); #1;
      cnt = 0; got = 1'b0; lat = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         if (cen_tog) cen = ~cen;
         @(negedge clk);
         if (ram_ok) begin
            got = 1'b1;
            lat = cnt + 1;
         end else begin
            cen_s = cen;
            @(posedge clk); #1;
            if (cen_s) cnt++;
         end
      end
      ram_rd = 1'b0; ram_we = 2'b00; cen = 1'b1;

      // reference model update
      if (is_wr) begin
         if (we[0]) ref_mem[{w[8:0], 1'b0}] = d[7:0];
         if (we[1]) ref_mem[{w[8:0], 1'b1}] = d[15:8];
         if (c_tag == w) c_valid = 1'b0;
      end else begin
         if (!hit) exp_dout = {ref_mem[{w[8:0], 1'b1}], ref_mem[{w[8:0], 1'b0}]};
         c_valid = 1'b1;
         c_tag   = w;
      end

      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: no ram_ok within budget", name);
      end else if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (ram_dout !== exp_dout) begin
         errors++;
         $display("FAIL %s ram_dout: got %h want %h", name, ram_dout, exp_dout);
      end
      @(posedge clk); #1;
      checks++;
      if (ram_ok !== 1'b0) begin
         errors++;
         $display("FAIL %s ok_pulse: ram_ok=%b want 0 after DONE", name, ram_ok);
      end
      checks++;
      if (cs_total - start !== exp_cs) begin
         errors++;
         $display("FAIL %s cs_cycles: got %0d want %0d", name, cs_total - start, exp_cs);
      end
      if (exp_cs > 0) begin
         checks++;
         if (cs_log[start % 4096] !== exp_first) begin
            errors++;
            $display("FAIL %s first_addr: got %h want %h", name, cs_log[start % 4096], exp_first);
         end
      end
      checks++;
      if (dev_mem[{w[8:0], 1'b0}] !== ref_mem[{w[8:0], 1'b0}] ||
          dev_mem[{w[8:0], 1'b1}] !== ref_mem[{w[8:0], 1'b1}]) begin
         errors++;
         $display("FAIL %s memory: got %h%h want %h%h", name,
                  dev_mem[{w[8:0], 1'b1}], dev_mem[{w[8:0], 1'b0}],
                  ref_mem[{w[8:0], 1'b1}], ref_mem[{w[8:0], 1'b0}]);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; cen = 1'b1; ram_addr = '0; ram_din = '0; ram_we = 2'b00; ram_rd = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ram_ok, ext_cs, ext_we} !== 3'b000 || ext_addr !== 24'h0 ||
          ext_dout !== 8'h0 || ram_dout !== 16'h0) begin
         errors++;
         $display("FAIL reset_values: ok=%b cs=%b we=%b addr=%h dout=%h rdout=%h want all 0",
                  ram_ok, ext_cs, ext_we, ext_addr, ext_dout, ram_dout);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_dout = 16'h0; c_valid = 1'b0; c_tag = '0;
   endtask

   task automatic test_read_basic;
      do_txn(24'h000100, 16'h1234, 2'b11, 1'b0, 1'b0, "seed_word");
      do_txn(24'h000101, 16'h0000, 2'b00, 1'b1, 1'b0, "read_basic");
      checks++;
      if (ram_dout !== 16'h1234) begin
         errors++;
         $display("FAIL read_value: got %h want 1234", ram_dout);
      end
   endtask

   task automatic test_write_hi;
      do_txn(24'h000200, 16'hAB55, 2'b10, 1'b0, 1'b0, "write_hi");
      do_txn(24'h000200, 16'h0000, 2'b00, 1'b1, 1'b0, "write_hi_rb");
   endtask

   task automatic test_priority;
      do_txn(24'h000210, 16'hC3A5, 2'b11, 1'b1, 1'b0, "rd_wr_both");
   endtask

   task automatic test_cen_toggle;
      do_txn(24'h000221, 16'h0000, 2'b00, 1'b1, 1'b1, "cen_read");
      do_txn(24'h000230, 16'h5AA5, 2'b01, 1'b0, 1'b1, "cen_write");
   endtask

   task automatic test_cache;
      do_txn(24'h000300, 16'h0000, 2'b00, 1'b1, 1'b0, "cache_fill");
      do_txn(24'h000300, 16'h0000, 2'b00, 1'b1, 1'b0, "cache_hit");
      do_txn(24'h000301, 16'h9900, 2'b10, 1'b0, 1'b0, "cache_inval");
      do_txn(24'h000300, 16'h0000, 2'b00, 1'b1, 1'b0, "cache_miss");
   endtask

   task automatic test_abort;
      bit seen;
      bit ok_seen;
      ram_addr = 24'h000120; ram_rd = 1'b1; ram_we = 2'b00; cen = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (ext_cs && ext_addr[0]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL abort_reach_hi: HI phase never observed");
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ext_cs, ext_we, ram_ok} !== 3'b000 || ram_dout !== 16'h0 || ext_addr !== 24'h0) begin
         errors++;
         $display("FAIL abort_async: cs=%b we=%b ok=%b rdout=%h addr=%h want zeros",
                  ext_cs, ext_we, ram_ok, ram_dout, ext_addr);
      end
      ram_rd = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_dout = 16'h0; c_valid = 1'b0;
      ok_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ram_ok) ok_seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (ok_seen) begin
         errors++;
         $display("FAIL abort_no_ok: ram_ok=1 seen after aborted access, want none");
      end
      do_txn(24'h000120, 16'h0000, 2'b00, 1'b1, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back;
      logic [22:0] w;
      bit          got, got2, hit2;
      int          k, exp_k;
      w = 23'h0000A8;
      ram_addr = {w, 1'b1}; ram_rd = 1'b1; ram_we = 2'b00; cen = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (ram_ok) got = 1'b1;
      end
      exp_dout = {ref_mem[{w[8:0], 1'b1}], ref_mem[{w[8:0], 1'b0}]};
      c_valid = 1'b1; c_tag = w;
      hit2  = CACHE;
      exp_k = 1 + (hit2 ? 0 : 2 * (W + 1)) + 1;
      k = 0; got2 = 1'b0;
      for (int i = 0; i < 100 && !got2; i++) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (ram_ok) got2 = 1'b1;
      end
      ram_rd = 1'b0;
      checks++;
      if (!got || !got2 || k !== exp_k) begin
         errors++;
         $display("FAIL back_to_back: got1=%b got2=%b gap %0d want %0d", got, got2, k, exp_k);
      end
      @(posedge clk); #1;
      checks++;
      if (ram_dout !== exp_dout) begin
         errors++;
         $display("FAIL back_to_back_dout: got %h want %h", ram_dout, exp_dout);
      end
   endtask

   task automatic test_random;
      logic [23:0] a;
      logic [1:0]  we;
      logic        rd;
      for (int n = 0; n < 40; n++) begin
         a  = 24'h000100 | 24'($urandom_range(0, 15) << 1) | 24'($urandom_range(0, 1));
         we = 2'($urandom_range(0, 3));
         rd = (we == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
         do_txn(a, 16'($urandom), we, rd, bit'($urandom_range(0, 3) == 0), "random");
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 11);
      test_reset;
      test_read_basic;
      test_write_hi;
      test_priority;
      test_cen_toggle;
      test_cache;
      test_abort;
      test_back_to_back;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jt900h_ram8_bridge.md
JT900H_RAM8_BRIDGE -- requirements
Module: jt900h_ram8_bridge

Interface
REQ-001 Parameter: WAIT, default 1, external wait states added to each byte phase (range 0..7).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cen  input  1  clock enable; when low, state, counters and all outputs hold.
REQ-005 ram_addr  input  24  byte address from the CPU RAM controller; bit 0 ignored (word access).
REQ-006 ram_din  input  16  write data; [7:0] goes to the even byte, [15:8] to the odd byte.
REQ-007 ram_we  input  2  byte write mask; [0] even byte, [1] odd byte.
REQ-008 ram_rd  input  1  read request strobe.
REQ-009 ram_dout  output  16  read data; [7:0] even byte, [15:8] odd byte.
REQ-010 ram_ok  output  1  one-cen-cycle completion pulse.
REQ-011 ext_addr  output  24  external 8-bit memory byte address.
REQ-012 ext_cs  output  1  external chip select.
REQ-013 ext_we  output  1  external write strobe, valid only with ext_cs.
REQ-014 ext_dout  output  8  external write data.
REQ-015 ext_din  input  8  external read data.

Function
REQ-016 States: IDLE, LO, HI, DONE; state advances only on cycles where cen=1.
REQ-017 IDLE: ram_we!=0 accepts a write; else ram_rd=1 accepts a read. On acceptance, {ram_addr[23:1],0}, ram_din and ram_we are latched. Write has priority when both are asserted.
REQ-018 Read: LO then HI; both bytes are always fetched.
REQ-019 Write: LO is entered only if mask[0]; HI only if mask[1]. A skipped phase takes zero cycles.
REQ-020 LO phase: ext_cs=1, ext_addr={word,0}, and for writes ext_we=1, ext_dout=latched din[7:0]. The phase lasts WAIT+1 cen cycles. For reads, ext_din is captured into ram_dout[7:0] on the last cycle.
REQ-021 HI phase: same as LO with ext_addr={word,1}, din[15:8] and ram_dout[15:8].
REQ-022 DONE: ext_cs=0, ext_we=0, ram_ok=1 for exactly one cen cycle, then IDLE.
REQ-023 Latency from acceptance edge to ram_ok high: 2*WAIT+3 cen cycles for a read or a two-byte write; WAIT+2 cen cycles for a one-byte write.
REQ-024 Requests arriving outside IDLE are ignored. The initiator holds its request until ram_ok. A request still present during the DONE cycle is not accepted until the IDLE cycle that follows.
REQ-025 ram_dout holds its last captured value and changes only during read phases; it is valid from the DONE cycle onward.
REQ-026 The wait counter is 3 bits, clears at every phase entry, and never wraps within a phase.
REQ-027 ext_cs and ext_we are registered outputs and are glitch-free between phases (they stay high across LO->HI).

Reset
REQ-028 While rst=1: state=IDLE, wait counter=0, ram_ok=0, ext_cs=0, ext_we=0, ext_addr=0, ext_dout=0, ram_dout=0, and the cache (if present) is invalid.
REQ-029 Asserting rst mid-access aborts the access immediately and asynchronously. ext_cs and ext_we drop without waiting for clk, and no ram_ok is issued.

Configuration
REQ-030 Macro JT900H_RAM8_RDCACHE_EN defined adds a one-word read cache: a tag (addr[23:1]) plus a valid bit, set when a read reaches DONE.
REQ-031 With the macro defined, a read in IDLE that hits a valid tag goes straight to DONE without ext_cs (ram_ok 1 cycle after acceptance), and ram_dout is unchanged. Any accepted write to the tagged word clears the valid bit.
REQ-032 Without the macro, no cache logic exists and every read follows REQ-018.

Verification
REQ-033 WAIT=0, ext memory [0x000100]=0x34, [0x000101]=0x12, ram_rd with ram_addr=0x000101 -> ext_addr 0x000100 then 0x000101, ram_ok 3 cycles after acceptance, ram_dout=0x1234.
REQ-034 WAIT=2, ram_we=2'b10, ram_din=0xAB55, ram_addr=0x000200 -> single ext_we phase of 3 cycles at ext_addr 0x000201 with ext_dout=0xAB, ram_ok 4 cycles after acceptance, byte 0x000200 untouched.
REQ-035 WAIT=1, ram_rd=1 and ram_we=2'b11 together -> write of both bytes performed, no read phases, ram_ok after 5 cycles.
REQ-036 cen toggled 1,0,1,0 during a WAIT=1 read -> phase length counted in cen-high cycles only, result identical to cen=1.
REQ-037 rst pulsed during HI phase of a read -> ext_cs=0 immediately, no ram_ok, next read completes normally.
REQ-038 Macro defined: read 0x000300, repeat same read -> second ram_ok after 1 cycle, no ext_cs; write to 0x000301 then read 0x000300 -> full external read.
